// File: rtl/decode_pkg.sv
// Shared decode types: opcode constants, field enums and the
// decoded-field bundle carried through the decode stage buffers.
package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] MRET  = 32'h30200073;
  localparam logic [31:0] ECALL = 32'h00000073;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100,
    IMM_Z = 3'b101
  } imm_src_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_CSR = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_write;
    logic     alu_src;
    logic     alu_src_a;
    logic     branch;
    logic     jump;
    logic     csr_we;
    logic     csr_re;
    logic     is_mret;
    logic     is_ecall;
    logic     illegal;
    imm_src_e imm_src;
    wb_sel_e  wb_sel;
    csr_op_e  csr_op;
  } dec_t;

endpackage

// File: rtl/decode_if.sv
// Decode stage bus: upstream and downstream valid/ready handshakes,
// flush, and the registered decode fields.
interface decode_if #(
  parameter int DW = 32
) ();

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_inst;
  logic [DW-1:0] in_pc;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_inst;
  logic [DW-1:0] out_pc;

  logic          reg_write;
  logic          mem_write;
  logic          alu_src;
  logic          alu_src_a;
  logic          branch;
  logic          jump;
  logic          csr_we;
  logic          csr_re;
  logic          is_mret;
  logic          is_ecall;
  logic          illegal;
  logic [2:0]    imm_src;
  logic [1:0]    wb_sel;
  logic [1:0]    csr_op;

  modport slave (
    input  flush, in_valid, in_inst, in_pc,
    input  out_ready,
    output in_ready, out_valid,
    output out_inst, out_pc,
    output reg_write, mem_write, alu_src,
    output alu_src_a, branch, jump,
    output csr_we, csr_re, is_mret,
    output is_ecall, illegal,
    output imm_src, wb_sel, csr_op
  );

  modport master (
    output flush, in_valid, in_inst, in_pc,
    output out_ready,
    input  in_ready, out_valid,
    input  out_inst, out_pc,
    input  reg_write, mem_write, alu_src,
    input  alu_src_a, branch, jump,
    input  csr_we, csr_re, is_mret,
    input  is_ecall, illegal,
    input  imm_src, wb_sel, csr_op
  );

endinterface

// File: rtl/inst_decode.sv
// Combinational RV32 instruction decoder: pure function of the
// instruction word, producing the decoded-field bundle.
module inst_decode
  import decode_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] inst,
  output dec_t          dec
);

  logic [31:0] w;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        rd_nz;
  logic        rs1_nz;

  assign w      = inst[31:0];
  assign op     = w[6:0];
  assign f3     = w[14:12];
  assign rd_nz  = |w[11:7];
  assign rs1_nz = |w[19:15];

  always_comb begin
    dec = '0;
    unique case (1'b1)
      op == OP_LOAD: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.imm_src   = IMM_I;
        dec.wb_sel    = WB_MEM;
      end
      op == OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.imm_src   = IMM_S;
      end
      op == OP_REG: begin
        dec.reg_write = 1'b1;
        dec.alu_src_a = 1'b1;
      end
      op == OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_src_a = 1'b1;
        dec.imm_src   = IMM_I;
      end
      op == OP_BRANCH: begin
        dec.branch  = 1'b1;
        dec.alu_src = 1'b1;
        dec.imm_src = IMM_B;
      end
      op == OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_J;
        dec.wb_sel    = WB_PC4;
      end
      op == OP_JALR: begin
        if (f3 == 3'b000) begin
          dec.reg_write = 1'b1;
          dec.jump      = 1'b1;
          dec.alu_src   = 1'b1;
          dec.alu_src_a = 1'b1;
          dec.imm_src   = IMM_I;
          dec.wb_sel    = WB_PC4;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      op == OP_LUI || op == OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_U;
      end
      op == OP_SYSTEM: begin
        if (f3 == 3'b000) begin
          if (w == MRET)
            dec.is_mret = 1'b1;
          else if (w == ECALL)
            dec.is_ecall = 1'b1;
          else
            dec.illegal = 1'b1;
        end else if (f3 == 3'b100) begin
          dec.illegal = 1'b1;
        end else begin
          // A zero rs1/uimm on set/clear suppresses the CSR write
          dec.csr_op    = csr_op_e'(f3[1:0]);
          dec.imm_src   = IMM_Z;
          dec.wb_sel    = WB_CSR;
          dec.reg_write = rd_nz;
          dec.csr_re    = (f3[1:0] != 2'b01) || rd_nz;
          dec.csr_we    = (f3[1:0] == 2'b01) || rs1_nz;
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: registered decode with an optional skid
// entry so the upstream sees full throughput under backpressure.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DW      = 32,
  parameter int SKID_EN = 1
) (
  input logic      clk,
  input logic      rst,
  decode_if.slave  bus
);

  dec_t          in_dec;
  dec_t          out_dec;
  dec_t          skid_dec;
  logic [DW-1:0] out_inst;
  logic [DW-1:0] out_pc;
  logic [DW-1:0] skid_inst;
  logic [DW-1:0] skid_pc;
  logic          out_valid;
  logic          skid_valid;
  logic          in_ready;
  logic          acc;
  logic          drain;
  logic          load_out;

  inst_decode #(.DW(DW)) u_dec (
    .inst (bus.in_inst),
    .dec  (in_dec)
  );

  assign in_ready = (SKID_EN != 0) ? !skid_valid
                  : (!out_valid || bus.out_ready);
  assign acc      = bus.in_valid && in_ready;
  assign drain    = out_valid && bus.out_ready;
  assign load_out = !out_valid || drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_inst   <= '0;
      out_pc     <= '0;
      out_dec    <= '0;
      skid_valid <= 1'b0;
      skid_inst  <= '0;
      skid_pc    <= '0;
      skid_dec   <= '0;
    end else if (bus.flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_out) begin
      // in_ready is low whenever skid holds a word, so no accept here
      if (skid_valid) begin
        out_inst   <= skid_inst;
        out_pc     <= skid_pc;
        out_dec    <= skid_dec;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (acc) begin
        out_inst  <= bus.in_inst;
        out_pc    <= bus.in_pc;
        out_dec   <= in_dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (acc && SKID_EN != 0) begin
      skid_inst  <= bus.in_inst;
      skid_pc    <= bus.in_pc;
      skid_dec   <= in_dec;
      skid_valid <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_inst  = out_inst;
  assign bus.out_pc    = out_pc;
  assign bus.reg_write = out_dec.reg_write;
  assign bus.mem_write = out_dec.mem_write;
  assign bus.alu_src   = out_dec.alu_src;
  assign bus.alu_src_a = out_dec.alu_src_a;
  assign bus.branch    = out_dec.branch;
  assign bus.jump      = out_dec.jump;
  assign bus.csr_we    = out_dec.csr_we;
  assign bus.csr_re    = out_dec.csr_re;
  assign bus.is_mret   = out_dec.is_mret;
  assign bus.is_ecall  = out_dec.is_ecall;
  assign bus.illegal   = out_dec.illegal;
  assign bus.imm_src   = out_dec.imm_src;
  assign bus.wb_sel    = out_dec.wb_sel;
  assign bus.csr_op    = out_dec.csr_op;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed cases plus random
// traffic, flushes and a mid-run reset against a reference model.
module tb_decode_stage;

  localparam int DW      = 32;
  localparam int SKID_EN = 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [17:0] f;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  decode_if #(.DW(DW)) bus ();

  decode_stage #(.DW(DW), .SKID_EN(SKID_EN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected flags straight from the opcode table, packed as
  // {rw,mw,as,asa,br,j,cwe,cre,mret,ecall,ill,imm[3],wb[2],cop[2]}
  function automatic logic [17:0] ref_flags(input logic [31:0] w);
    logic rw, mw, as_, asa, br, j, cwe, cre, mr, ec, ill;
    logic [2:0] imm;
    logic [1:0] wb, cop;
    logic [2:0] f3;
    {rw, mw, as_, asa, br, j, cwe, cre, mr, ec, ill} = '0;
    imm = 3'd0; wb = 2'd0; cop = 2'd0;
    f3  = w[14:12];
    case (w[6:0])
      7'h03: begin rw = 1; as_ = 1; asa = 1; wb = 2'd1; end
      7'h23: begin mw = 1; as_ = 1; asa = 1; imm = 3'd1; end
      7'h33: begin rw = 1; asa = 1; end
      7'h13: begin rw = 1; as_ = 1; asa = 1; end
      7'h63: begin br = 1; as_ = 1; imm = 3'd2; end
      7'h6F: begin rw = 1; j = 1; as_ = 1; imm = 3'd3; wb = 2'd2; end
      7'h67: begin
        if (f3 == 0) begin
          rw = 1; j = 1; as_ = 1; asa = 1; wb = 2'd2;
        end else ill = 1;
      end
      7'h37, 7'h17: begin rw = 1; as_ = 1; imm = 3'd4; end
      7'h73: begin
        if (f3 == 0) begin
          if (w == 32'h30200073) mr = 1;
          else if (w == 32'h00000073) ec = 1;
          else ill = 1;
        end else if (f3 == 4) ill = 1;
        else begin
          cop = f3[1:0];
          imm = 3'd5;
          wb  = 2'd3;
          rw  = (w[11:7] != 0);
          cre = (cop != 2'd1) || (w[11:7] != 0);
          cwe = (cop == 2'd1) || (w[19:15] != 0);
        end
      end
      default: ill = 1;
    endcase
    return {rw, mw, as_, asa, br, j, cwe, cre, mr, ec, ill,
            imm, wb, cop};
  endfunction

  function automatic logic [17:0] dut_flags();
    return {bus.reg_write, bus.mem_write, bus.alu_src,
            bus.alu_src_a, bus.branch, bus.jump, bus.csr_we,
            bus.csr_re, bus.is_mret, bus.is_ecall, bus.illegal,
            bus.imm_src, bus.wb_sel, bus.csr_op};
  endfunction

  task automatic chk_b(input string nm, input logic a,
                       input logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  task automatic chk_w(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // Output monitor: occupancy, handshake and in-order contents
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      chk_b("rst_out_valid", bus.out_valid, 1'b0);
      chk_w("rst_flags", 32'(dut_flags()), 32'd0);
      chk_w("rst_inst", bus.out_inst | bus.out_pc, 32'd0);
    end else begin
      chk_b("out_valid", bus.out_valid, q.size() > 0);
      chk_b("in_ready", bus.in_ready,
            (SKID_EN != 0) ? (q.size() < 2)
                           : (q.size() == 0 || bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stale_output: got inst %h expected none",
                   bus.out_inst);
        end else begin
          e = q.pop_front();
          chk_w("out_inst", bus.out_inst, e.inst);
          chk_w("out_pc", bus.out_pc, e.pc);
          chk_w("out_flags", 32'(dut_flags()), 32'(e.f));
        end
      end
    end
  end

  // Input recorder: pushes expectations for accepted words
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (bus.flush)
        q.delete();
      else if (bus.in_valid && bus.in_ready)
        q.push_back('{bus.in_inst, bus.in_pc,
                      ref_flags(bus.in_inst)});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] p);
    bus.in_valid = 1'b1;
    bus.in_inst  = w;
    bus.in_pc    = p;
    step();
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] r;
    logic [31:0] pool [10];
    logic [6:0]  ops [10];
    pool = '{32'h00012083, 32'h00000033, 32'h00100093, 32'h30002073,
             32'h300110F3, 32'h30200073, 32'h00000073, 32'hFFFFFFFF,
             32'h00004073, 32'h00001067};
    ops  = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63,
             7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       return pool[$urandom_range(0, 9)];
      1:       return {r[31:7], ops[$urandom_range(0, 9)]};
      default: return r;
    endcase
  endfunction

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk_b("in_ready_after_rst", bus.in_ready, 1'b1);
    step();

    bus.out_ready = 1'b1;
    send(32'h00012083, 32'h100);
    chk_b("lw_valid", bus.out_valid, 1'b1);
    chk_b("lw_reg_write", bus.reg_write, 1'b1);
    chk_w("lw_wb_sel", 32'(bus.wb_sel), 32'd1);
    chk_w("lw_imm_src", 32'(bus.imm_src), 32'd0);
    step();

    bus.out_ready = 1'b0;
    send(32'h00000033, 32'h104);
    send(32'h00100093, 32'h108);
    chk_b("skid_full_ready", bus.in_ready, 1'b0);
    chk_w("stall_head", bus.out_inst, 32'h00000033);
    step();
    chk_w("stall_hold", bus.out_inst, 32'h00000033);
    bus.out_ready = 1'b1;
    step();
    chk_w("second_out", bus.out_inst, 32'h00100093);
    step();
    chk_b("drained", bus.out_valid, 1'b0);

    send(32'h30002073, 32'h10C);
    chk_b("csrrs_re", bus.csr_re, 1'b1);
    chk_b("csrrs_we", bus.csr_we, 1'b0);
    chk_b("csrrs_rw", bus.reg_write, 1'b0);
    send(32'h300110F3, 32'h110);
    chk_b("csrrw_we", bus.csr_we, 1'b1);
    chk_b("csrrw_re", bus.csr_re, 1'b1);
    chk_w("csrrw_wb", 32'(bus.wb_sel), 32'd3);

    send(32'h30200073, 32'h114);
    chk_b("mret", bus.is_mret, 1'b1);
    chk_b("mret_rw", bus.reg_write, 1'b0);
    send(32'hFFFFFFFF, 32'h118);
    chk_b("ill", bus.illegal, 1'b1);
    chk_w("ill_writes", 32'(dut_flags()), 32'h00080);
    chk_w("ill_pc", bus.out_pc, 32'h118);
    step();

    bus.out_ready = 1'b0;
    send(32'h00000033, 32'h200);
    send(32'h00100093, 32'h204);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_inst  = 32'h00012083;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk_b("flush_valid", bus.out_valid, 1'b0);
    chk_b("flush_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    repeat (4) step();

    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 31) == 0);
      bus.in_inst   = pick();
      bus.in_pc     = $urandom;
      rst           = (i == 1500);
      step();
    end
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    chk_w("queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
